fu_logical_pipe: RTL and testbench
==================================

FU_LOGICAL_PIPE -- requirements
Module: fu_logical_pipe

Interface
REQ-001 SHALL have parameter INST_ID_BITS, default 6, instruction-ID width.
REQ-002 SHALL have parameter PRN_BITS, default 6, physical register number width.
REQ-003 SHALL have parameter MAX_OPERANDS, default 3, operand and result lane count (minimum 2).
REQ-004 SHALL have parameter STAGES, default 2, execute pipeline depth (minimum 1).
REQ-005 SHALL have parameter FIFO_DEPTH, default 3, output buffer entries (minimum 1).
REQ-006 SHALL have ports, one per line:
- clk  in  1  clock; one clock domain only.
- rst  in  1  reset; asynchronous, active-high.
- inst_id  in  INST_ID_BITS  instruction tag.
- inst  in  32  AArch64 encoding.
- op  in  MAX_OPERANDS x 64  source operands; op[0]=Rn, op[1]=Rm.
- out_prn  in  MAX_OPERANDS x PRN_BITS  destination PRNs per lane.
- pc  in  64  instruction PC; carried but unused.
- inst_valid  in  1  issue request.
- flush  in  1  discard all in-flight and buffered work.
- out_ready  in  1  consumer accepts output this cycle.
- fu_ready  out  1  unit accepts an issue this cycle.
- fu_out_valid  out  1  output entry present.
- fu_out_inst_id  out  INST_ID_BITS  tag of the output entry.
- fu_out_prn  out  MAX_OPERANDS x PRN_BITS  destination PRNs.
- fu_out_data  out  MAX_OPERANDS x 64  result per lane.
- fu_out_data_valid  out  MAX_OPERANDS x 1  lane write enables.

Function
REQ-007 SHALL accept an instruction only when inst_valid and fu_ready are both 1 on a rising edge.
REQ-008 SHALL decode the logical shifted-register fields sf=inst[31], opc=inst[30:29], shift=inst[23:22] (LSL/LSR/ASR/ROR), N=inst[21], imm6=inst[15:10].
REQ-009 SHALL compute Rn op (N ? ~shift(Rm) : shift(Rm)) with op AND for opc 00/11, ORR for 01, EOR for 10 (covers AND, BIC, ORR, ORN, EOR, EON, ANDS, BICS).
REQ-010 SHALL, when sf=0, operate on bits [31:0] with shift amount imm6[4:0], and zero-extend the result to 64 bits.
REQ-011 SHALL drive lane 0 with the result and fu_out_data_valid[0]=1; all other lanes SHALL have data_valid=0 unless REQ-012 applies.
REQ-012 SHALL, for opc=11 (flags feature enabled), drive lane 1 as {60'b0, N, Z, C=0, V=0} with data_valid[1]=1; N is the result MSB at the operating width and Z is (result==0) at the operating width.
REQ-013 SHALL present an accepted instruction on the outputs exactly STAGES cycles after acceptance when the output buffer is empty; the buffer is first-word-fall-through.
REQ-014 SHALL hold all outputs stable while fu_out_valid=1 and out_ready=0.
REQ-015 SHALL pop the head entry on a rising edge where fu_out_valid and out_ready are both 1.
REQ-016 SHALL keep a credit counter in the range 0..FIFO_DEPTH: decrement on accept, increment on pop, unchanged when both occur in the same cycle; fu_ready SHALL equal (credits != 0).
REQ-017 SHALL never overflow the buffer; with FIFO_DEPTH >= STAGES+1 and out_ready held at 1, throughput SHALL be one instruction per cycle.
REQ-018 SHALL, on flush, on the next edge: clear all pipeline valids and buffer entries and set credits to FIFO_DEPTH. An issue in the same cycle as flush SHALL be dropped. fu_out_valid SHALL be 0 in the following cycle.
REQ-019 SHALL preserve issue order at the outputs.

Reset
REQ-020 SHALL, on rst, asynchronously set fu_out_valid=0, all fu_out_data_valid=0, fu_out_data=0, fu_out_prn=0, fu_out_inst_id=0, credits=FIFO_DEPTH (so fu_ready=1 after release), and clear all pipeline valids.
REQ-021 SHALL discard in-flight work on reset asserted mid-operation, with no output produced after release.

Configuration
REQ-022 SHALL compile the flags lane only when FU_LOGICAL_PIPE_FLAGS_EN is defined.
REQ-023 SHALL, when FU_LOGICAL_PIPE_FLAGS_EN is undefined, treat ANDS and BICS as AND and BIC: lane 0 only, data_valid[1]=0.

Structure
REQ-024 SHALL place the logical-op and shift-type enums and the instruction field bit positions in the shared package fu_logical_pkg.
REQ-025 SHALL implement the combinational shift/logic/flags datapath as sub-module fu_logical_alu, instantiated at stage 1.

Verification
REQ-026 ORR x, sf=1, Rn=0xF0, Rm=0x0F, LSL #4 -> after STAGES cycles lane0=0xF0, data_valid={0,0,1} with the matching inst_id.
REQ-027 ANDS w, sf=0, Rn=0x8000_0000, Rm=0xFFFF_FFFF -> lane0=0x0000_0000_8000_0000, lane1=0x8 (N=1), data_valid[1]=1; with the macro undefined, data_valid[1]=0.
REQ-028 EON x, Rn=0, Rm=0x1, ROR #1 -> lane0=0x7FFF_FFFF_FFFF_FFFF.
REQ-029 Issue back-to-back with out_ready=0 -> exactly FIFO_DEPTH accepts, then fu_ready=0; one pop -> fu_ready=1 on the next cycle; entries drain in issue order.
REQ-030 Flush with 2 in flight plus a concurrent issue -> no fu_out_valid afterwards, credits=FIFO_DEPTH.
REQ-031 rst asserted mid-pipeline, asynchronous to clk -> outputs zero immediately, fu_ready=1 after release, no stale output.

Source files
------------

// File: rtl/fu_logical_pkg.sv
// Shared definitions for the logical shifted-register unit: op/shift enums,
// instruction field positions and the operand shifter helpers.
package fu_logical_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_ORR  = 2'b01,
        OP_EOR  = 2'b10,
        OP_ANDS = 2'b11
    } logic_op_e;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_e;

    localparam int SF_BIT    = 31;
    localparam int OPC_MSB   = 30;
    localparam int OPC_LSB   = 29;
    localparam int SHIFT_MSB = 23;
    localparam int SHIFT_LSB = 22;
    localparam int N_BIT     = 21;
    localparam int IMM6_MSB  = 15;
    localparam int IMM6_LSB  = 10;

    // A rotate by zero shifts left by the full width, which yields zero.
    function automatic logic [63:0] shift64(input logic [63:0] v, input shift_e sh,
                                            input logic [5:0] amt);
        logic [63:0] r;
        case (sh)
            SH_LSL:  r = v << amt;
            SH_LSR:  r = v >> amt;
            SH_ASR:  r = $unsigned($signed(v) >>> amt);
            default: r = (v >> amt) | (v << (7'd64 - {1'b0, amt}));
        endcase
        return r;
    endfunction

    function automatic logic [31:0] shift32(input logic [31:0] v, input shift_e sh,
                                            input logic [4:0] amt);
        logic [31:0] r;
        case (sh)
            SH_LSL:  r = v << amt;
            SH_LSR:  r = v >> amt;
            SH_ASR:  r = $unsigned($signed(v) >>> amt);
            default: r = (v >> amt) | (v << (6'd32 - {1'b0, amt}));
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fu_logical_pipe_if.sv
// Issue/result bundle for fu_logical_pipe; master is the issuer/consumer side,
// slave is the execution unit.
interface fu_logical_pipe_if #(
    parameter int INST_ID_BITS = 6,
    parameter int PRN_BITS     = 6,
    parameter int MAX_OPERANDS = 3
);
    logic [INST_ID_BITS-1:0]               inst_id;
    logic [31:0]                           inst;
    logic [MAX_OPERANDS-1:0][63:0]         op;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] out_prn;
    logic [63:0]                           pc;
    logic                                  inst_valid;
    logic                                  flush;
    logic                                  out_ready;
    logic                                  fu_ready;
    logic                                  fu_out_valid;
    logic [INST_ID_BITS-1:0]               fu_out_inst_id;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] fu_out_prn;
    logic [MAX_OPERANDS-1:0][63:0]         fu_out_data;
    logic [MAX_OPERANDS-1:0]               fu_out_data_valid;

    modport master (
        output inst_id, inst, op, out_prn, pc, inst_valid, flush, out_ready,
        input  fu_ready, fu_out_valid, fu_out_inst_id, fu_out_prn, fu_out_data,
               fu_out_data_valid
    );

    modport slave (
        input  inst_id, inst, op, out_prn, pc, inst_valid, flush, out_ready,
        output fu_ready, fu_out_valid, fu_out_inst_id, fu_out_prn, fu_out_data,
               fu_out_data_valid
    );
endinterface

// File: rtl/fu_logical_alu.sv
// Combinational shift/logic/flags datapath for AArch64 logical shifted-register ops.
// The NZCV flags lane exists only when FU_LOGICAL_PIPE_FLAGS_EN is defined.
module fu_logical_alu
    import fu_logical_pkg::*;
(
    input  logic [31:0] inst_i,
    input  logic [63:0] rn_i,
    input  logic [63:0] rm_i,
    output logic [63:0] result_o,
    output logic [3:0]  flags_o,
    output logic        flags_valid_o
);
    logic        sf;
    logic        inv;
    logic [5:0]  imm6;
    logic_op_e   opc;
    shift_e      sh;
    logic [63:0] operand;
    logic [63:0] res;
    logic        unused_inst;

    assign sf          = inst_i[SF_BIT];
    assign inv         = inst_i[N_BIT];
    assign imm6        = inst_i[IMM6_MSB:IMM6_LSB];
    assign opc         = logic_op_e'(inst_i[OPC_MSB:OPC_LSB]);
    assign sh          = shift_e'(inst_i[SHIFT_MSB:SHIFT_LSB]);
    assign unused_inst = ^{inst_i[28:24], inst_i[20:16], inst_i[9:0]};

    always_comb begin
        operand = sf ? shift64(rm_i, sh, imm6) : {32'b0, shift32(rm_i[31:0], sh, imm6[4:0])};
        if (inv) begin
            operand = ~operand;
        end
        case (opc)
            OP_ORR:  res = rn_i | operand;
            OP_EOR:  res = rn_i ^ operand;
            default: res = rn_i & operand;
        endcase
        // W-form results are zero-extended, which also makes the Z test width-agnostic.
        if (!sf) begin
            res[63:32] = '0;
        end
    end

    assign result_o = res;

`ifdef FU_LOGICAL_PIPE_FLAGS_EN
    logic flag_n;
    logic flag_z;
    assign flag_n        = sf ? res[63] : res[31];
    assign flag_z        = (res == 64'd0);
    assign flags_o       = {flag_n, flag_z, 2'b00};
    assign flags_valid_o = (opc == OP_ANDS);
`else
    assign flags_o       = 4'b0000;
    assign flags_valid_o = 1'b0;
`endif

endmodule

// File: rtl/fu_logical_pipe.sv
// Pipelined logical-op functional unit: STAGES-deep execute, credit-guarded FWFT
// output buffer. Optional flags lane via FU_LOGICAL_PIPE_FLAGS_EN (see fu_logical_alu).
module fu_logical_pipe
    import fu_logical_pkg::*;
#(
    parameter int INST_ID_BITS = 6,
    parameter int PRN_BITS     = 6,
    parameter int MAX_OPERANDS = 3,
    parameter int STAGES       = 2,
    parameter int FIFO_DEPTH   = 3
) (
    input logic            clk,
    input logic            rst,
    fu_logical_pipe_if.slave bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [INST_ID_BITS-1:0]               id;
        logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] prn;
        logic [MAX_OPERANDS-1:0][63:0]         data;
        logic [MAX_OPERANDS-1:0]               dv;
    } entry_t;

    logic [63:0]      alu_result;
    logic [3:0]       alu_flags;
    logic             alu_flags_valid;
    entry_t           issue_ent;
    entry_t           wr_ent;
    entry_t           head;
    logic             wr_valid;
    logic             accept;
    logic             push;
    logic             pop;
    logic             out_valid;
    logic             unused_in;

    entry_t           mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] credits_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign unused_in = ^{bus.pc, bus.op};

    fu_logical_alu u_alu (
        .inst_i        (bus.inst),
        .rn_i          (bus.op[0]),
        .rm_i          (bus.op[1]),
        .result_o      (alu_result),
        .flags_o       (alu_flags),
        .flags_valid_o (alu_flags_valid)
    );

    always_comb begin
        issue_ent         = '0;
        issue_ent.id      = bus.inst_id;
        issue_ent.prn     = bus.out_prn;
        issue_ent.data[0] = alu_result;
        issue_ent.dv[0]   = 1'b1;
        issue_ent.data[1] = {60'b0, alu_flags};
        issue_ent.dv[1]   = alu_flags_valid;
    end

    // Credits reserve a buffer slot at issue time, so the pipe never needs to stall.
    assign accept = bus.inst_valid & (credits_q != '0) & ~bus.flush;
    assign pop    = out_valid & bus.out_ready;
    assign push   = wr_valid & ~bus.flush;

    generate
        if (STAGES == 1) begin : g_direct
            assign wr_valid = accept;
            assign wr_ent   = issue_ent;
        end else begin : g_pipe
            logic [STAGES-2:0] vld_q;
            entry_t            ent_q [STAGES-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= '0;
                    for (int i = 0; i < STAGES - 1; i++) begin
                        ent_q[i] <= '0;
                    end
                end else begin
                    vld_q[0] <= accept;
                    if (accept) begin
                        ent_q[0] <= issue_ent;
                    end
                    for (int i = 1; i < STAGES - 1; i++) begin
                        vld_q[i] <= vld_q[i-1] & ~bus.flush;
                        ent_q[i] <= ent_q[i-1];
                    end
                end
            end

            assign wr_valid = vld_q[STAGES-2];
            assign wr_ent   = ent_q[STAGES-2];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            credits_q <= CNT_W'(FIFO_DEPTH);
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (bus.flush) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            credits_q <= CNT_W'(FIFO_DEPTH);
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wr_ent;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            case ({accept, pop})
                2'b10:   credits_q <= credits_q - 1'b1;
                2'b01:   credits_q <= credits_q + 1'b1;
                default: credits_q <= credits_q;
            endcase
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign out_valid = (count_q != '0);

    assign bus.fu_ready          = (credits_q != '0);
    assign bus.fu_out_valid      = out_valid;
    assign bus.fu_out_inst_id    = out_valid ? head.id   : '0;
    assign bus.fu_out_prn        = out_valid ? head.prn  : '0;
    assign bus.fu_out_data       = out_valid ? head.data : '0;
    assign bus.fu_out_data_valid = out_valid ? head.dv   : '0;

endmodule

// File: tb/tb_fu_logical_pipe.sv
// Self-checking bench for fu_logical_pipe: queue-based reference model with a
// per-cycle compare process, plus directed vectors with literal expectations.
module tb_fu_logical_pipe;
    localparam int IDB   = 6;
    localparam int PRNB  = 6;
    localparam int OPS   = 3;
    localparam int STG   = 2;
    localparam int DEPTH = 3;
`ifdef FU_LOGICAL_PIPE_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    typedef struct {
        logic [IDB-1:0]      id;
        logic [OPS*PRNB-1:0] prn;
        logic [63:0]         l0;
        logic [63:0]         l1;
        logic                dv1;
        int                  rdy;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    dut_acc = 0;
    exp_t  q[$];
    exp_t  ne;
    bit    mv, mr;

    logic [31:0] vi [8];
    logic [63:0] vn [8];
    logic [63:0] vm [8];
    logic [63:0] pin_l0 [8];
    logic [63:0] l0, l1;
    logic        dv1;

    always #5 clk = ~clk;

    fu_logical_pipe_if #(.INST_ID_BITS(IDB), .PRN_BITS(PRNB), .MAX_OPERANDS(OPS)) bus ();

    fu_logical_pipe #(
        .INST_ID_BITS(IDB), .PRN_BITS(PRNB), .MAX_OPERANDS(OPS),
        .STAGES(STG), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] mk(input bit sf, input bit [1:0] opc, input bit [1:0] sh,
                                       input bit n, input bit [5:0] imm);
        return {sf, opc, 5'b01010, sh, n, 5'd2, imm, 5'd1, 5'd0};
    endfunction

    // Architectural meaning of the instruction, evaluated at the operating width.
    function automatic void model_exec(input logic [31:0] ins, input logic [63:0] rn,
                                       input logic [63:0] rm, output logic [63:0] o0,
                                       output logic [63:0] o1, output logic odv1);
        int          w;
        int          amt;
        logic [63:0] mask, a, b, r;
        w    = ins[31] ? 64 : 32;
        mask = ins[31] ? {64{1'b1}} : 64'h0000_0000_FFFF_FFFF;
        amt  = ins[31] ? int'(ins[15:10]) : int'(ins[14:10]);
        a    = rn & mask;
        b    = rm & mask;
        case (ins[23:22])
            2'd0: b = (b << amt) & mask;
            2'd1: b = b >> amt;
            2'd2: begin
                if (b[w-1]) b = (b >> amt) | (mask & ~(mask >> amt));
                else        b = b >> amt;
            end
            default: if (amt != 0) b = ((b >> amt) | (b << (w - amt))) & mask;
        endcase
        if (ins[21]) b = ~b & mask;
        case (ins[30:29])
            2'd1:    r = a | b;
            2'd2:    r = a ^ b;
            default: r = a & b;
        endcase
        o0   = r;
        o1   = {60'd0, r[w-1], (r == 64'd0), 2'b00};
        odv1 = FLAGS && (ins[30:29] == 2'd3);
    endfunction

    // Model update on each rising edge, using the inputs the DUT samples.
    always @(posedge clk) begin
        if (rst || bus.flush) begin
            q.delete();
        end else begin
            mv = (q.size() > 0) && (q[0].rdy <= cyc);
            mr = (q.size() < DEPTH);
            if (bus.inst_valid && bus.fu_ready) dut_acc++;
            if (mv && bus.out_ready) void'(q.pop_front());
            if (bus.inst_valid && mr) begin
                ne.id  = bus.inst_id;
                ne.prn = bus.out_prn;
                model_exec(bus.inst, bus.op[0], bus.op[1], ne.l0, ne.l1, ne.dv1);
                ne.rdy = cyc + STG;
                q.push_back(ne);
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (rst) begin
            check("rst_ready", {63'd0, bus.fu_ready}, 64'd1);
            check("rst_valid", {63'd0, bus.fu_out_valid}, 64'd0);
            check("rst_id", {58'd0, bus.fu_out_inst_id}, 64'd0);
            check("rst_prn", {46'd0, bus.fu_out_prn}, 64'd0);
            check("rst_data", {63'd0, |bus.fu_out_data}, 64'd0);
            check("rst_dv", {61'd0, bus.fu_out_data_valid}, 64'd0);
        end else begin
            mv = (q.size() > 0) && (q[0].rdy <= cyc);
            check("fu_ready", {63'd0, bus.fu_ready}, {63'd0, q.size() < DEPTH});
            check("out_valid", {63'd0, bus.fu_out_valid}, {63'd0, mv});
            if (mv) begin
                check("out_id", {58'd0, bus.fu_out_inst_id}, {58'd0, q[0].id});
                check("out_prn", {46'd0, bus.fu_out_prn}, {46'd0, q[0].prn});
                check("lane0", bus.fu_out_data[0], q[0].l0);
                check("out_dv", {61'd0, bus.fu_out_data_valid}, {61'd0, 1'b0, q[0].dv1, 1'b1});
                if (q[0].dv1) check("lane1", bus.fu_out_data[1], q[0].l1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [IDB-1:0] id, input logic [31:0] ins,
                         input logic [63:0] rn, input logic [63:0] rm);
        bus.inst_id    = id;
        bus.inst       = ins;
        bus.op[0]      = rn;
        bus.op[1]      = rm;
        bus.op[2]      = 64'hA5A5_5A5A_C3C3_3C3C;
        bus.out_prn[0] = PRNB'(id);
        bus.out_prn[1] = PRNB'(id + 6'd1);
        bus.out_prn[2] = PRNB'(id + 6'd2);
        bus.pc         = {58'd0, id} << 2;
        bus.inst_valid = 1'b1;
        step();
        bus.inst_valid = 1'b0;
    endtask

    initial begin
        bus.inst_id = '0; bus.inst = '0; bus.op = '0; bus.out_prn = '0; bus.pc = '0;
        bus.inst_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1;

        vi[0] = mk(1, 2'd1, 2'd0, 0, 6'd4);  vn[0] = 64'hF0;                  vm[0] = 64'h0F;
        vi[1] = mk(0, 2'd3, 2'd0, 0, 6'd0);  vn[1] = 64'h8000_0000;           vm[1] = 64'hFFFF_FFFF;
        vi[2] = mk(1, 2'd2, 2'd3, 1, 6'd1);  vn[2] = 64'h0;                   vm[2] = 64'h1;
        vi[3] = mk(0, 2'd0, 2'd2, 1, 6'd4);  vn[3] = 64'hFFFF_FFFF;           vm[3] = 64'h8000_0000;
        vi[4] = mk(1, 2'd1, 2'd1, 1, 6'd60); vn[4] = 64'h0;                   vm[4] = 64'hF000_0000_0000_0000;
        vi[5] = mk(0, 2'd2, 2'd0, 0, 6'd31); vn[5] = 64'hFFFF_FFFF_0000_0001; vm[5] = 64'h3;
        vi[6] = mk(1, 2'd3, 2'd1, 0, 6'd8);  vn[6] = 64'hFF;                  vm[6] = 64'hFF;
        vi[7] = mk(0, 2'd3, 2'd3, 1, 6'd4);  vn[7] = 64'hFFFF_FFFF;           vm[7] = 64'hF;
        pin_l0[0] = 64'hF0;
        pin_l0[1] = 64'h0000_0000_8000_0000;
        pin_l0[2] = 64'h7FFF_FFFF_FFFF_FFFF;
        pin_l0[3] = 64'h0000_0000_07FF_FFFF;
        pin_l0[4] = 64'hFFFF_FFFF_FFFF_FFF0;
        pin_l0[5] = 64'h0000_0000_8000_0001;
        pin_l0[6] = 64'h0;
        pin_l0[7] = 64'h0000_0000_0FFF_FFFF;

        // Pin the model against hand-computed results.
        for (int i = 0; i < 8; i++) begin
            model_exec(vi[i], vn[i], vm[i], l0, l1, dv1);
            check($sformatf("pin_l0_%0d", i), l0, pin_l0[i]);
        end
        model_exec(vi[1], vn[1], vm[1], l0, l1, dv1);
        check("pin_ands_nzcv", l1, 64'h8);
        check("pin_ands_dv1", {63'd0, dv1}, {63'd0, FLAGS});
        model_exec(vi[6], vn[6], vm[6], l0, l1, dv1);
        check("pin_zero_nzcv", l1, 64'h4);

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        step();

        // ORR x, LSL #4: visible exactly STAGES cycles after acceptance.
        issue(6'd1, vi[0], vn[0], vm[0]);
        check("orr_not_early", {63'd0, bus.fu_out_valid}, 64'd0);
        step();
        check("orr_valid", {63'd0, bus.fu_out_valid}, 64'd1);
        check("orr_lane0", bus.fu_out_data[0], 64'hF0);
        check("orr_dv", {61'd0, bus.fu_out_data_valid}, 64'd1);
        check("orr_id", {58'd0, bus.fu_out_inst_id}, 64'd1);

        issue(6'd2, vi[1], vn[1], vm[1]);
        step();
        check("ands_lane0", bus.fu_out_data[0], 64'h0000_0000_8000_0000);
        check("ands_dv", {61'd0, bus.fu_out_data_valid}, FLAGS ? 64'd3 : 64'd1);

        issue(6'd3, vi[2], vn[2], vm[2]);
        step();
        check("eon_lane0", bus.fu_out_data[0], 64'h7FFF_FFFF_FFFF_FFFF);
        repeat (3) step();

        // Mixed stream with intermittent backpressure.
        for (int i = 0; i < 8; i++) begin
            bus.out_ready = (i % 3 != 2);
            issue(IDB'(8 + i), vi[i], vn[i], vm[i]);
        end
        bus.out_ready = 1'b1;
        repeat (6) step();

        // Fill the buffer with the consumer stalled.
        bus.out_ready = 1'b0;
        dut_acc = 0;
        for (int i = 0; i < 5; i++) issue(IDB'(20 + i), vi[i], vn[i], vm[i]);
        check("fill_accepts", dut_acc, DEPTH);
        check("fill_ready_low", {63'd0, bus.fu_ready}, 64'd0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("pop_ready_high", {63'd0, bus.fu_ready}, 64'd1);
        check("pop_next_id", {58'd0, bus.fu_out_inst_id}, 64'd21);
        step();
        bus.out_ready = 1'b1;
        repeat (6) step();

        // Flush with two in flight and a concurrent issue.
        issue(6'd30, vi[3], vn[3], vm[3]);
        issue(6'd31, vi[4], vn[4], vm[4]);
        bus.flush = 1'b1;
        issue(6'd32, vi[5], vn[5], vm[5]);
        bus.flush = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("flush_no_valid", {63'd0, bus.fu_out_valid}, 64'd0);
            check("flush_ready", {63'd0, bus.fu_ready}, 64'd1);
            step();
        end
        bus.out_ready = 1'b0;
        dut_acc = 0;
        for (int i = 0; i < 4; i++) issue(IDB'(33 + i), vi[i], vn[i], vm[i]);
        check("flush_credits", dut_acc, DEPTH);
        bus.out_ready = 1'b1;
        repeat (6) step();

        // Asynchronous reset mid-pipeline.
        issue(6'd40, vi[6], vn[6], vm[6]);
        issue(6'd41, vi[7], vn[7], vm[7]);
        #2 rst = 1'b1;
        q.delete();
        #1;
        check("arst_valid", {63'd0, bus.fu_out_valid}, 64'd0);
        check("arst_data", {63'd0, |bus.fu_out_data}, 64'd0);
        check("arst_dv", {61'd0, bus.fu_out_data_valid}, 64'd0);
        repeat (2) step();
        #2 rst = 1'b0;
        check("arst_ready_after", {63'd0, bus.fu_ready}, 64'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            check("arst_no_stale", {63'd0, bus.fu_out_valid}, 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
